// File: rtl/video_pkg.sv
// Shared 720p timing constants, frame-size helper and pixel/timing types
// for the video timing generator and its delay line.
package video_pkg;

  localparam int H_ACTIVE_720 = 1280;
  localparam int H_FP_720     = 110;
  localparam int H_SYNC_720   = 40;
  localparam int H_BP_720     = 220;
  localparam int V_ACTIVE_720 = 720;
  localparam int V_FP_720     = 5;
  localparam int V_SYNC_720   = 5;
  localparam int V_BP_720     = 20;

  localparam logic [23:0] BG_COLOR_DEF = 24'h000040;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } timing_t;

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Parameterized-depth shift register that delays the raw {de,hs,vs} bundle
// to match the compositor pipeline latency.
module sync_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: this array is only a few flops deep, so every stage is reset to keep
  // sync/de outputs clean right after reset; large RAM-style arrays would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's
      // old value, so the loop order cannot collapse the shift register.
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing source: issues coordinates and raw vsync to the
// compositors, then registers their colour with delayed sync and data-enable.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int          H_ACTIVE   = H_ACTIVE_720,
  parameter int          H_FP       = H_FP_720,
  parameter int          H_SYNC     = H_SYNC_720,
  parameter int          H_BP       = H_BP_720,
  parameter int          V_ACTIVE   = V_ACTIVE_720,
  parameter int          V_FP       = V_FP_720,
  parameter int          V_SYNC     = V_SYNC_720,
  parameter int          V_BP       = V_BP_720,
  parameter bit          SYNC_POL   = 1'b1,
  parameter int          PIPE_DELAY = 1,
  parameter logic [23:0] BG_COLOR   = BG_COLOR_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_v_sync_raw,
  output logic        o_frame_tick,
  input  logic [7:0]  i_red,
  input  logic [7:0]  i_green,
  input  logic [7:0]  i_blue,
  input  logic        i_sprite_hit,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_de
);

  localparam int          H_TOTAL  = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int          V_TOTAL  = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] v_cnt_q, v_cnt_d;
  logic        h_last, v_last;
  timing_t     raw, dly;
  pixel_t      pix_q, pix_d, bg_pix;
  logic        de_q, hs_q, vs_q;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    h_last  = (h_cnt_q == H_LAST);
    v_last  = (v_cnt_q == V_LAST);
    h_cnt_d = h_last ? '0 : h_cnt_q + 16'd1;
    v_cnt_d = v_cnt_q;
    if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    raw    = '0;
    raw.de = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    raw.hs = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    raw.vs = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  end

  assign o_x          = h_cnt_q;
  assign o_y          = v_cnt_q;
  assign o_v_sync_raw = SYNC_POL ? raw.vs : ~raw.vs;
  assign o_frame_tick = (v_cnt_q == VS_START) && (h_cnt_q == '0);

  sync_delay_line #(
    .DEPTH (PIPE_DELAY),
    .WIDTH ($bits(timing_t))
  ) u_sync_delay_line (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d_i   (raw),
    .q_o   (dly)
  );

  // Colour arriving now belongs to the coordinate whose de is leaving the delay line.
  assign bg_pix = BG_COLOR;

  always_comb begin
    pix_d = '0;
    if (dly.de) begin
      if (i_sprite_hit) begin
        pix_d.r = i_red;
        pix_d.g = i_green;
        pix_d.b = i_blue;
      end else begin
        pix_d = bg_pix;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      pix_q <= pix_d;
      de_q  <= dly.de;
      hs_q  <= dly.hs;
      vs_q  <= dly.vs;
    end
  end

  // Syncs are held active-high internally so reset maps to the inactive level.
  assign o_h_sync = SYNC_POL ? hs_q : ~hs_q;
  assign o_v_sync = SYNC_POL ? vs_q : ~vs_q;
  assign o_de     = de_q;
  assign o_red    = pix_q.r;
  assign o_green  = pix_q.g;
  assign o_blue   = pix_q.b;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: dut_a runs full 720p timing (PIPE_DELAY=1); dut_b runs a
// shrunken raster (32x17 total, PIPE_DELAY=3) so whole frames fit in a short run.
module tb_video_timing_gen;

  localparam int BH  = 32;  // dut_b: 20 active + 4 fp + 3 sync + 5 bp
  localparam int BV  = 17;  // dut_b: 10 active + 2 fp + 2 sync + 3 bp
  localparam int BLAT = 4;  // dut_b PIPE_DELAY + 1
  localparam int ALAT = 2;  // dut_a PIPE_DELAY + 1

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] a_x, a_y, b_x, b_y;
  logic        a_vsr, a_tick, a_hs, a_vs, a_de;
  logic        b_vsr, b_tick, b_hs, b_vs, b_de;
  logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
  logic [7:0]  bi_r = 8'h00, bi_g = 8'h00, bi_b = 8'h00;
  logic        bi_hit = 1'b0;

  video_timing_gen #(.PIPE_DELAY(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .o_x(a_x), .o_y(a_y),
    .o_v_sync_raw(a_vsr), .o_frame_tick(a_tick),
    .i_red(8'h00), .i_green(8'h00), .i_blue(8'h00), .i_sprite_hit(1'b0),
    .o_red(a_r), .o_green(a_g), .o_blue(a_b),
    .o_h_sync(a_hs), .o_v_sync(a_vs), .o_de(a_de)
  );

  video_timing_gen #(
    .H_ACTIVE(20), .H_FP(4), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1), .PIPE_DELAY(3), .BG_COLOR(24'h000040)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .o_x(b_x), .o_y(b_y),
    .o_v_sync_raw(b_vsr), .o_frame_tick(b_tick),
    .i_red(bi_r), .i_green(bi_g), .i_blue(bi_b), .i_sprite_hit(bi_hit),
    .o_red(b_r), .o_green(b_g), .o_blue(b_b),
    .o_h_sync(b_hs), .o_v_sync(b_vs), .o_de(b_de)
  );

  // Small raster model for dut_b, indexed by clocks since reset release.
  function automatic bit b_de_at(input int c);
    return ((c % BH) < 20) && (((c / BH) % BV) < 10);
  endfunction
  function automatic bit b_hs_at(input int c);
    return ((c % BH) >= 24) && ((c % BH) < 27);
  endfunction
  function automatic bit b_vs_at(input int c);
    return (((c / BH) % BV) >= 12) && (((c / BH) % BV) < 14);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0 after release (counters at 0,0).
  task automatic reset_release();
    rst_n = 1'b0;
    repeat (10) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) tick();
    checks++; if ({a_x, a_y} !== 32'h0) begin errors++; $display("FAIL rst_a_xy: got %h/%h want 0/0", a_x, a_y); end
    checks++; if ({a_de, a_hs, a_vs, a_vsr, a_tick} !== 5'b0) begin errors++; $display("FAIL rst_a_ctl: got de/hs/vs/vsr/tick=%b%b%b%b%b want 00000", a_de, a_hs, a_vs, a_vsr, a_tick); end
    checks++; if ({a_r, a_g, a_b} !== 24'h0) begin errors++; $display("FAIL rst_a_rgb: got %h%h%h want 000000", a_r, a_g, a_b); end
    checks++; if ({b_de, b_hs, b_vs, b_vsr, b_tick} !== 5'b0) begin errors++; $display("FAIL rst_b_ctl: got de/hs/vs/vsr/tick=%b%b%b%b%b want 00000", b_de, b_hs, b_vs, b_vsr, b_tick); end
    checks++; if ({b_r, b_g, b_b, b_x, b_y} !== 56'h0) begin errors++; $display("FAIL rst_b_rgbxy: got %h%h%h %h/%h want 0", b_r, b_g, b_b, b_x, b_y); end
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      checks++; if (a_x !== 16'(n) || a_y !== 16'h0) begin errors++; $display("FAIL start_a_xy[%0d]: got %0d/%0d want %0d/0", n, a_x, a_y, n); end
      checks++; if (a_de !== (n >= ALAT)) begin errors++; $display("FAIL start_a_de[%0d]: got %b want %b", n, a_de, n >= ALAT); end
      checks++; if (b_de !== (n >= BLAT)) begin errors++; $display("FAIL start_b_de[%0d]: got %b want %b", n, b_de, n >= BLAT); end
      checks++; if (a_b !== ((n >= ALAT) ? 8'h40 : 8'h00)) begin errors++; $display("FAIL start_a_blue[%0d]: got %h want %h", n, a_b, (n >= ALAT) ? 8'h40 : 8'h00); end
      tick();
    end
  endtask

  task automatic test_lines();
    int mism = 0, de_l0 = 0, de_l1 = 0, hs_cnt = 0, hs_rise = -1;
    bit prev_hs = 1'b0;
    reset_release();
    for (int n = 0; n < 2 * 1650 + ALAT; n++) begin
      int hd = (n - ALAT) % 1650;
      bit e_de = (n >= ALAT) && (hd < 1280);
      bit e_hs = (n >= ALAT) && (hd >= 1390) && (hd < 1430);
      if (a_x !== 16'(n % 1650) || a_y !== 16'(n / 1650) || a_de !== e_de || a_hs !== e_hs) mism++;
      if (a_de === 1'b1 && n < 1650 + ALAT) de_l0++;
      if (a_de === 1'b1 && n >= 1650 + ALAT) de_l1++;
      if (a_hs === 1'b1) hs_cnt++;
      if (a_hs === 1'b1 && !prev_hs && hs_rise < 0) hs_rise = n;
      prev_hs = a_hs;
      tick();
    end
    checks++; if (mism != 0) begin errors++; $display("FAIL lines_per_cycle: mismatching cycles=%0d want 0", mism); end
    checks++; if (de_l0 != 1280) begin errors++; $display("FAIL lines_de_line0: got %0d want 1280", de_l0); end
    checks++; if (de_l1 != 1280) begin errors++; $display("FAIL lines_de_line1: got %0d want 1280", de_l1); end
    checks++; if (hs_cnt != 80) begin errors++; $display("FAIL lines_hs_width: got %0d want 80", hs_cnt); end
    checks++; if (hs_rise != 1390 + ALAT) begin errors++; $display("FAIL lines_hs_start: got %0d want %0d", hs_rise, 1390 + ALAT); end
  endtask

  task automatic test_frame();
    int mism = 0, ticks = 0, vsr_cnt = 0, vs_cnt = 0, de_cnt = 0;
    logic [15:0] tx = 16'hffff, ty = 16'hffff;
    reset_release();
    for (int n = 0; n < BH * BV; n++) begin
      int c = n - BLAT;
      bit e_de = (n >= BLAT) && b_de_at(c);
      bit e_hs = (n >= BLAT) && b_hs_at(c);
      bit e_vs = (n >= BLAT) && b_vs_at(c);
      bit e_tick = ((n / BH) == 12) && ((n % BH) == 0);
      if (b_x !== 16'(n % BH) || b_y !== 16'(n / BH) || b_vsr !== b_vs_at(n) || b_tick !== e_tick ||
          b_de !== e_de || b_hs !== e_hs || b_vs !== e_vs || b_b !== (e_de ? 8'h40 : 8'h00)) mism++;
      if (b_tick === 1'b1) begin ticks++; tx = b_x; ty = b_y; end
      if (b_vsr === 1'b1) vsr_cnt++;
      if (b_vs === 1'b1) vs_cnt++;
      if (b_de === 1'b1) de_cnt++;
      tick();
    end
    checks++; if (mism != 0) begin errors++; $display("FAIL frame_per_cycle: mismatching cycles=%0d want 0", mism); end
    checks++; if (ticks != 1) begin errors++; $display("FAIL frame_tick_count: got %0d want 1", ticks); end
    checks++; if (tx !== 16'd0 || ty !== 16'd12) begin errors++; $display("FAIL frame_tick_pos: got %0d/%0d want 0/12", tx, ty); end
    checks++; if (vsr_cnt != 64) begin errors++; $display("FAIL frame_vsync_raw_len: got %0d want 64", vsr_cnt); end
    checks++; if (vs_cnt != 64) begin errors++; $display("FAIL frame_vsync_len: got %0d want 64", vs_cnt); end
    checks++; if (de_cnt != 200) begin errors++; $display("FAIL frame_de_count: got %0d want 200", de_cnt); end
    checks++; if (b_x !== 16'd0 || b_y !== 16'd0) begin errors++; $display("FAIL frame_restart: got %0d/%0d want 0/0", b_x, b_y); end
  endtask

  // Sprite pixel at (5,3): coordinate issued on cycle 101, colour driven 3 cycles later.
  task automatic test_sprite();
    int mism = 0, hits = 0;
    reset_release();
    for (int n = 0; n < 130; n++) begin
      logic [23:0] exp_rgb;
      int c = n - BLAT;
      exp_rgb = 24'h0;
      if (n >= BLAT && b_de_at(c)) exp_rgb = (n == 105) ? 24'h2121ff : 24'h000040;
      if ({b_r, b_g, b_b} !== exp_rgb) mism++;
      if ({b_r, b_g, b_b} === 24'h2121ff) hits++;
      if (n == 104 || n == 105 || n == 106) begin
        checks++; if ({b_r, b_g, b_b} !== exp_rgb) begin errors++; $display("FAIL sprite_px[%0d]: got %h%h%h want %h", n, b_r, b_g, b_b, exp_rgb); end
      end
      bi_hit = (n == 104);
      {bi_r, bi_g, bi_b} = (n == 104) ? 24'h2121ff : 24'haaaaaa;
      tick();
    end
    bi_hit = 1'b0;
    {bi_r, bi_g, bi_b} = 24'h0;
    checks++; if (mism != 0) begin errors++; $display("FAIL sprite_per_cycle: mismatching cycles=%0d want 0", mism); end
    checks++; if (hits != 1) begin errors++; $display("FAIL sprite_count: got %0d want 1", hits); end
  endtask

  task automatic test_blanking();
    int mism = 0, blank_seen = 0;
    reset_release();
    bi_hit = 1'b1;
    {bi_r, bi_g, bi_b} = 24'hffffff;
    for (int n = 0; n <= 70; n++) begin
      bit e_de = (n >= BLAT) && b_de_at(n - BLAT);
      if (b_de !== e_de || {b_r, b_g, b_b} !== (e_de ? 24'hffffff : 24'h0)) mism++;
      if (n >= BLAT && b_de === 1'b0 && {b_r, b_g, b_b} === 24'h0) blank_seen++;
      tick();
    end
    bi_hit = 1'b0;
    {bi_r, bi_g, bi_b} = 24'h0;
    checks++; if (mism != 0) begin errors++; $display("FAIL blank_per_cycle: mismatching cycles=%0d want 0", mism); end
    checks++; if (blank_seen != 24) begin errors++; $display("FAIL blank_zero_rgb: got %0d blank cycles with rgb 0 want 24", blank_seen); end
  endtask

  task automatic test_async_reset();
    reset_release();
    repeat (5 * BH + 10) tick();
    checks++; if (b_x !== 16'd10 || b_y !== 16'd5) begin errors++; $display("FAIL arst_pre_xy: got %0d/%0d want 10/5", b_x, b_y); end
    checks++; if (b_de !== 1'b1 || b_b !== 8'h40 || a_b !== 8'h40) begin errors++; $display("FAIL arst_pre_out: got de=%b b_blue=%h a_blue=%h want 1/40/40", b_de, b_b, a_b); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (b_x !== 16'd0 || b_y !== 16'd0 || a_x !== 16'd0) begin errors++; $display("FAIL arst_xy: got b=%0d/%0d a_x=%0d want 0", b_x, b_y, a_x); end
    checks++; if ({b_de, b_hs, b_vs, b_vsr, b_tick} !== 5'b0 || {b_r, b_g, b_b} !== 24'h0) begin errors++; $display("FAIL arst_b_out: got ctl=%b%b%b%b%b rgb=%h%h%h want 0", b_de, b_hs, b_vs, b_vsr, b_tick, b_r, b_g, b_b); end
    checks++; if (a_de !== 1'b0 || {a_r, a_g, a_b} !== 24'h0) begin errors++; $display("FAIL arst_a_out: got de=%b rgb=%h%h%h want 0", a_de, a_r, a_g, a_b); end
    repeat (3) tick();
    rst_n = 1'b1;
    checks++; if (b_x !== 16'd0 || b_y !== 16'd0) begin errors++; $display("FAIL arst_restart0: got %0d/%0d want 0/0", b_x, b_y); end
    repeat (3) tick();
    checks++; if (b_x !== 16'd3 || b_y !== 16'd0) begin errors++; $display("FAIL arst_restart3: got %0d/%0d want 3/0", b_x, b_y); end
  endtask

  initial begin
    test_reset();
    test_lines();
    test_frame();
    test_sprite();
    test_blanking();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
